// File: rtl/mc_ctrl_pkg.sv
// Shared state codes, instruction decode constants and datapath select encodings
// for the multicycle controller.
package mc_ctrl_pkg;

    localparam int STATE_CODE_W = 6;

    typedef enum logic [STATE_CODE_W-1:0] {
        S_RST     = 6'd0,
        S_FETCH   = 6'd1,
        S_DECODE  = 6'd2,
        S_EXEC_R  = 6'd3,
        S_WB_R    = 6'd4,
        S_ADDR    = 6'd5,
        S_MEM_LD  = 6'd6,
        S_LD_WB   = 6'd7,
        S_MEM_ST  = 6'd8,
        S_BRANCH  = 6'd9,
        S_ADDI_EX = 6'd10,
        S_ADDI_WB = 6'd11,
        S_JUMP    = 6'd12,
        S_JR      = 6'd13,
        S_EXC     = 6'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    localparam logic [1:0] ASA_PC      = 2'd0;
    localparam logic [1:0] ASA_A       = 2'd1;

    localparam logic [2:0] ASB_B       = 3'd0;
    localparam logic [2:0] ASB_4       = 3'd1;
    localparam logic [2:0] ASB_IMM     = 3'd2;
    localparam logic [2:0] ASB_IMM_SL2 = 3'd3;

    localparam logic [2:0] ALU_ADD     = 3'd0;
    localparam logic [2:0] ALU_SUB     = 3'd1;
    localparam logic [2:0] ALU_FUNCT   = 3'd2;

    localparam logic [2:0] PCS_ALU     = 3'd0;
    localparam logic [2:0] PCS_ALUOUT  = 3'd1;
    localparam logic [2:0] PCS_JUMP    = 3'd2;
    localparam logic [2:0] PCS_REG_A   = 3'd3;
    localparam logic [2:0] PCS_EXC     = 3'd4;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_LD) || (s == S_MEM_ST);
    endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// Memory-access wait counter: counts 0..MEM_WAIT while enabled, flags the final cycle.
// last is combinational from the count; wraps to 0 on the final cycle, cleared when idle.
module mc_wait_counter #(
    parameter int MEM_WAIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CW = (MEM_WAIT < 2) ? 1 : $clog2(MEM_WAIT + 1);

    logic [CW-1:0] cnt;

    assign last = (cnt == CW'(MEM_WAIT));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control FSM; Moore strobes decoded from the registered state (MC_CTRL_EXCEPTION_EN adds EXC).
// Memory states hold MEM_WAIT+1 cycles; no handshake, synchronous Reset aborts any access at the next edge.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1,
    parameter int STATE_W  = 6
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         Funct,
    input  logic               Overflow,
    output logic [STATE_W-1:0] Estado,
    output logic               PCWrite,
    output logic               BranchEq,
    output logic               BranchNe,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               MemToReg,
    output logic [1:0]         AluSrcA,
    output logic [2:0]         AluSrcB,
    output logic [2:0]         AluOp,
`ifdef MC_CTRL_EXCEPTION_EN
    output logic               EPCWrite,
    output logic               CauseWrite,
    output logic [0:0]         Cause,
`endif
    output logic [2:0]         PCSource
);

    state_t state;
    logic   in_mem;
    logic   last;

    assign in_mem = is_mem_state(state);
    assign Estado = STATE_W'(state);

    mc_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk  (Clock),
        .rst  (Reset),
        .clr  (!in_mem),
        .en   (in_mem),
        .last (last)
    );

`ifdef MC_CTRL_EXCEPTION_EN
    logic       ovf_trap;
    logic [0:0] cause_q;

    // Only signed add/sub trap; addu-style functs write back regardless.
    always_comb begin
        ovf_trap = 1'b0;
        if (state == S_WB_R)
            ovf_trap = Overflow && ((Funct == FN_ADD) || (Funct == FN_SUB));
        else if (state == S_ADDI_WB)
            ovf_trap = Overflow;
    end

    assign Cause = (state == S_EXC) ? cause_q : 1'b0;
`else
    logic unused_overflow;
    assign unused_overflow = Overflow;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_RST;
`ifdef MC_CTRL_EXCEPTION_EN
            cause_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_RST:    state <= S_FETCH;
                S_FETCH:  if (last) state <= S_DECODE;
                S_DECODE: begin
                    case (Opcode)
                        OP_RTYPE:      state <= (Funct == FN_JR) ? S_JR : S_EXEC_R;
                        OP_LW, OP_SW:  state <= S_ADDR;
                        OP_BEQ, OP_BNE: state <= S_BRANCH;
                        OP_ADDI:       state <= S_ADDI_EX;
                        OP_J:          state <= S_JUMP;
                        default: begin
`ifdef MC_CTRL_EXCEPTION_EN
                            state   <= S_EXC;
                            cause_q <= 1'b1;
`else
                            state <= S_FETCH;
`endif
                        end
                    endcase
                end
                S_EXEC_R:  state <= S_WB_R;
                S_ADDR:    state <= (Opcode == OP_SW) ? S_MEM_ST : S_MEM_LD;
                S_MEM_LD:  if (last) state <= S_LD_WB;
                S_MEM_ST:  if (last) state <= S_FETCH;
                S_ADDI_EX: state <= S_ADDI_WB;
                S_WB_R, S_ADDI_WB: begin
`ifdef MC_CTRL_EXCEPTION_EN
                    if (ovf_trap) begin
                        state   <= S_EXC;
                        cause_q <= 1'b0;
                    end else begin
                        state <= S_FETCH;
                    end
`else
                    state <= S_FETCH;
`endif
                end
                S_LD_WB, S_BRANCH, S_JUMP, S_JR, S_EXC: state <= S_FETCH;
                default:   state <= S_RST;
            endcase
        end
    end

    always_comb begin
        PCWrite  = 1'b0;
        BranchEq = 1'b0;
        BranchNe = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemToReg = 1'b0;
        AluSrcA  = ASA_PC;
        AluSrcB  = ASB_B;
        AluOp    = ALU_ADD;
        PCSource = PCS_ALU;
`ifdef MC_CTRL_EXCEPTION_EN
        EPCWrite   = 1'b0;
        CauseWrite = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                AluSrcB = ASB_4;
                IRWrite = last;
                PCWrite = last;
            end
            S_DECODE: AluSrcB = ASB_IMM_SL2;
            S_EXEC_R: begin
                AluSrcA = ASA_A;
                AluOp   = ALU_FUNCT;
            end
            S_WB_R: begin
`ifdef MC_CTRL_EXCEPTION_EN
                RegWrite = !ovf_trap;
`else
                RegWrite = 1'b1;
`endif
                RegDst = 1'b1;
            end
            S_ADDR, S_ADDI_EX: begin
                AluSrcA = ASA_A;
                AluSrcB = ASB_IMM;
            end
            S_MEM_LD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_LD_WB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEM_ST: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_BRANCH: begin
                AluSrcA  = ASA_A;
                AluOp    = ALU_SUB;
                PCSource = PCS_ALUOUT;
                BranchEq = (Opcode == OP_BEQ);
                BranchNe = (Opcode == OP_BNE);
            end
            S_ADDI_WB: begin
`ifdef MC_CTRL_EXCEPTION_EN
                RegWrite = !ovf_trap;
`else
                RegWrite = 1'b1;
`endif
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCS_JUMP;
            end
            S_JR: begin
                PCWrite  = 1'b1;
                PCSource = PCS_REG_A;
            end
            S_EXC: begin
`ifdef MC_CTRL_EXCEPTION_EN
                EPCWrite   = 1'b1;
                CauseWrite = 1'b1;
`endif
                PCWrite  = 1'b1;
                PCSource = PCS_EXC;
                AluSrcB  = ASB_4;
                AluOp    = ALU_SUB;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: instance 1 uses MEM_WAIT=2, instance 0 uses MEM_WAIT=0.
module tb_mc_control_unit;

    localparam int ST_RST = 0, ST_FETCH = 1, ST_DECODE = 2, ST_WB_R = 4;
    localparam int ST_MEM_ST = 8, ST_ADDI_WB = 11, ST_EXC = 14;

    logic       clk = 1'b0;
    logic [1:0] rst = 2'b11;
    logic [5:0] op [2];
    logic [5:0] fn [2];
    logic [1:0] ov = 2'b00;

    logic [5:0] est [2];
    logic [1:0] pcw, beqo, bneo, iord, mrd, mwr, irw, rgw, rdst, m2r;
    logic [1:0] asa [2];
    logic [2:0] asb [2];
    logic [2:0] aop [2];
    logic [2:0] pcso [2];
    logic [1:0] epcw, causew;
    logic [0:0] cause [2];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         d;
        logic [5:0] op;
        logic [5:0] fn;
        int cyc, mr, mw, rw, pw, irat, beq, bne, pcs;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [NV];

    always #5 clk = ~clk;

    mc_control_unit #(.MEM_WAIT(0), .STATE_W(6)) u_dut0 (
        .Clock(clk), .Reset(rst[0]), .Opcode(op[0]), .Funct(fn[0]), .Overflow(ov[0]),
        .Estado(est[0]), .PCWrite(pcw[0]), .BranchEq(beqo[0]), .BranchNe(bneo[0]),
        .IorD(iord[0]), .MemRead(mrd[0]), .MemWrite(mwr[0]), .IRWrite(irw[0]),
        .RegWrite(rgw[0]), .RegDst(rdst[0]), .MemToReg(m2r[0]), .AluSrcA(asa[0]),
        .AluSrcB(asb[0]), .AluOp(aop[0]),
`ifdef MC_CTRL_EXCEPTION_EN
        .EPCWrite(epcw[0]), .CauseWrite(causew[0]), .Cause(cause[0]),
`endif
        .PCSource(pcso[0])
    );

    mc_control_unit #(.MEM_WAIT(2), .STATE_W(6)) u_dut1 (
        .Clock(clk), .Reset(rst[1]), .Opcode(op[1]), .Funct(fn[1]), .Overflow(ov[1]),
        .Estado(est[1]), .PCWrite(pcw[1]), .BranchEq(beqo[1]), .BranchNe(bneo[1]),
        .IorD(iord[1]), .MemRead(mrd[1]), .MemWrite(mwr[1]), .IRWrite(irw[1]),
        .RegWrite(rgw[1]), .RegDst(rdst[1]), .MemToReg(m2r[1]), .AluSrcA(asa[1]),
        .AluSrcB(asb[1]), .AluOp(aop[1]),
`ifdef MC_CTRL_EXCEPTION_EN
        .EPCWrite(epcw[1]), .CauseWrite(causew[1]), .Cause(cause[1]),
`endif
        .PCSource(pcso[1])
    );

`ifndef MC_CTRL_EXCEPTION_EN
    initial begin
        epcw = 2'b00;
        causew = 2'b00;
        cause[0] = 1'b0;
        cause[1] = 1'b0;
    end
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] outs(input int s);
        logic [31:0] r;
        r = {11'd0, pcw[s], beqo[s], bneo[s], iord[s], mrd[s], mwr[s], irw[s], rgw[s],
             rdst[s], m2r[s], asa[s], asb[s], aop[s], pcso[s]};
        r = r | {29'd0, epcw[s], causew[s], cause[s]};
        return r;
    endfunction

    // Ends at a negedge inside the first FETCH cycle.
    task automatic release_dut(input int s, input string tag);
        @(posedge clk);
        #1 rst[s] = 1'b0;
        @(negedge clk);
        chk($sformatf("%s_rst_state", tag), 32'(est[s]), ST_RST);
        chk($sformatf("%s_rst_outs", tag), outs(s), 0);
        @(negedge clk);
        chk($sformatf("%s_fetch_after_rst", tag), 32'(est[s]), ST_FETCH);
    endtask

    task automatic reset_dut(input int s, input string tag);
        @(posedge clk);
        #1 rst[s] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk($sformatf("%s_hold_state", tag), 32'(est[s]), ST_RST);
        chk($sformatf("%s_hold_outs", tag), outs(s), 0);
        release_dut(s, tag);
    endtask

    task automatic wait_state(input int s, input int code, input string nm);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (32'(est[s]) == code) break;
        end
        chk(nm, 32'(est[s]), code);
    endtask

    // Entry and exit: negedge in the first FETCH cycle of the selected instance.
    task automatic apply_row(input int i);
        vec_t v;
        int s, cyc, mr, mw, rw, pw, irat, nbeq, nbne, pcs, conf;
        logic [5:0] prev;
        v = tbl[i];
        s = v.d;
        op[s] = v.op;
        fn[s] = v.fn;
        cyc = 0; mr = 0; mw = 0; rw = 0; pw = 0; nbeq = 0; nbne = 0; conf = 0;
        irat = -1; pcs = 7;
        prev = est[s];
        for (int k = 0; k < 60; k++) begin
            if (k > 0 && 32'(est[s]) == ST_FETCH && 32'(prev) != ST_FETCH) break;
            mr += int'(mrd[s]);
            mw += int'(mwr[s]);
            rw += int'(rgw[s]);
            pw += int'(pcw[s]);
            nbeq += int'(beqo[s]);
            nbne += int'(bneo[s]);
            if (irw[s]) irat = cyc;
            if (pcw[s] || beqo[s] || bneo[s]) pcs = int'(pcso[s]);
            if (int'(pcw[s]) + int'(beqo[s]) + int'(bneo[s]) > 1) conf++;
            prev = est[s];
            cyc++;
            @(negedge clk);
        end
        chk($sformatf("row%0d_cycles", i), cyc, v.cyc);
        chk($sformatf("row%0d_memread", i), mr, v.mr);
        chk($sformatf("row%0d_memwrite", i), mw, v.mw);
        chk($sformatf("row%0d_regwrite", i), rw, v.rw);
        chk($sformatf("row%0d_pcwrite", i), pw, v.pw);
        chk($sformatf("row%0d_irwrite_at", i), irat, v.irat);
        chk($sformatf("row%0d_brancheq", i), nbeq, v.beq);
        chk($sformatf("row%0d_branchne", i), nbne, v.bne);
        chk($sformatf("row%0d_pcsource", i), pcs, v.pcs);
        chk($sformatf("row%0d_pc_conflict", i), conf, 0);
    endtask

    initial begin
        op[0] = 6'h00; fn[0] = 6'h00;
        op[1] = 6'h00; fn[1] = 6'h00;

        //          d  op     fn     cyc mr mw rw pw irat beq bne pcs
        tbl[0]  = '{1, 6'h00, 6'h20, 6,  3, 0, 1, 1, 2,   0,  0,  0};
        tbl[1]  = '{1, 6'h00, 6'h22, 6,  3, 0, 1, 1, 2,   0,  0,  0};
        tbl[2]  = '{1, 6'h00, 6'h08, 5,  3, 0, 0, 2, 2,   0,  0,  3};
        tbl[3]  = '{1, 6'h23, 6'h00, 9,  6, 0, 1, 1, 2,   0,  0,  0};
        tbl[4]  = '{1, 6'h2B, 6'h00, 8,  3, 3, 0, 1, 2,   0,  0,  0};
        tbl[5]  = '{1, 6'h08, 6'h00, 6,  3, 0, 1, 1, 2,   0,  0,  0};
        tbl[6]  = '{1, 6'h02, 6'h00, 5,  3, 0, 0, 2, 2,   0,  0,  2};
`ifdef MC_CTRL_EXCEPTION_EN
        tbl[7]  = '{1, 6'h3F, 6'h00, 5,  3, 0, 0, 2, 2,   0,  0,  4};
`else
        tbl[7]  = '{1, 6'h3F, 6'h00, 4,  3, 0, 0, 1, 2,   0,  0,  0};
`endif
        tbl[8]  = '{0, 6'h04, 6'h00, 3,  1, 0, 0, 1, 0,   1,  0,  1};
        tbl[9]  = '{0, 6'h05, 6'h00, 3,  1, 0, 0, 1, 0,   0,  1,  1};
        tbl[10] = '{0, 6'h23, 6'h00, 5,  2, 0, 1, 1, 0,   0,  0,  0};
        tbl[11] = '{0, 6'h00, 6'h08, 3,  1, 0, 0, 2, 0,   0,  0,  3};

        reset_dut(1, "mw2");
        for (int i = 0; i < 8; i++) apply_row(i);

        // Reset during the second MEM_ST cycle must kill MemWrite at that edge.
        op[1] = 6'h2B;
        wait_state(1, ST_MEM_ST, "st_reach");
        @(negedge clk);
        rst[1] = 1'b1;
        chk("st_mw_before_abort", 32'(mwr[1]), 1);
        @(negedge clk);
        chk("st_mw_after_abort", 32'(mwr[1]), 0);
        chk("st_state_after_abort", 32'(est[1]), ST_RST);
        release_dut(1, "st_abort");

        // addi overflow
        op[1] = 6'h08;
        ov[1] = 1'b1;
        wait_state(1, ST_ADDI_WB, "addi_wb_reach");
`ifdef MC_CTRL_EXCEPTION_EN
        chk("addi_ovf_regwrite", 32'(rgw[1]), 0);
        @(negedge clk);
        chk("addi_ovf_exc", 32'(est[1]), ST_EXC);
        chk("addi_ovf_epcwrite", 32'(epcw[1]), 1);
        chk("addi_ovf_causewrite", 32'(causew[1]), 1);
        chk("addi_ovf_cause", 32'(cause[1]), 0);
        chk("addi_ovf_pcwrite", 32'(pcw[1]), 1);
        chk("addi_ovf_pcsource", 32'(pcso[1]), 4);
        @(negedge clk);
        chk("exc_to_fetch", 32'(est[1]), ST_FETCH);
        op[1] = 6'h00;
        fn[1] = 6'h20;
        wait_state(1, ST_WB_R, "add_wb_reach");
        chk("add_ovf_regwrite", 32'(rgw[1]), 0);
        @(negedge clk);
        chk("add_ovf_exc", 32'(est[1]), ST_EXC);
        ov[1] = 1'b0;
        @(negedge clk);
        op[1] = 6'h3F;
        wait_state(1, ST_DECODE, "bad_op_decode");
        @(negedge clk);
        chk("bad_op_exc", 32'(est[1]), ST_EXC);
        chk("bad_op_cause", 32'(cause[1]), 1);
        chk("bad_op_epcwrite", 32'(epcw[1]), 1);
        @(negedge clk);
        chk("bad_op_to_fetch", 32'(est[1]), ST_FETCH);
`else
        chk("addi_ovf_ignored_regwrite", 32'(rgw[1]), 1);
        @(negedge clk);
        chk("addi_ovf_ignored_fetch", 32'(est[1]), ST_FETCH);
        ov[1] = 1'b0;
`endif

        release_dut(0, "mw0");
        for (int i = 8; i < NV; i++) apply_row(i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
